// File: rtl/aes_pkg.sv
// Shared AES types and helpers for the MixColumns sequencer and its word datapath.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package aes_pkg;

  // Full 128-bit AES state, column c at bits [127-32c : 96-32c]
  typedef logic [127:0] state_t;

  // One 32-bit column, row 0 in the top byte
  typedef logic [31:0] word_t;

  // Sequencer FSM states; the fourth encoding is unused and recovers to IDLE
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MIX  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  localparam int NUM_COLS = 4;
  localparam int COL_W    = 32;

  // Multiply a byte by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Extract column c of a state, column 0 being the most significant word
  function automatic word_t get_col(input state_t s, input logic [1:0] c);
    return s[(NUM_COLS - 1 - int'(c)) * COL_W +: COL_W];
  endfunction

endpackage

// File: rtl/mixCol32.sv
// MixColumns transform of a single 32-bit AES column.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller samples the result when it needs it.
module mixCol32
  import aes_pkg::*;
(
  input  word_t word,
  output word_t mixed
);

  logic [7:0] a0;
  logic [7:0] a1;
  logic [7:0] a2;
  logic [7:0] a3;
  logic [7:0] b0;
  logic [7:0] b1;
  logic [7:0] b2;
  logic [7:0] b3;

  assign {a0, a1, a2, a3} = word;

  // Circulant matrix rows {2,3,1,1}; 3*a is written as xtime(a) ^ a
  always_comb begin
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  assign mixed = {b0, b1, b2, b3};

endmodule

// File: rtl/mix_col_sequencer.sv
// Applies MixColumns to a 128-bit AES state one column per cycle through one shared word datapath.
// Latency: out_valid rises on the 4th edge after accept (on the accept edge itself in bypass).
// Backpressure: result is held in DONE until out_ready; no new accept until the FSM is back in IDLE.
module mix_col_sequencer
  import aes_pkg::*;
#(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  seq_state_t          state;
  logic [1:0]          cnt;
  logic                bypass_q;
  state_t              work;

  logic                accept;
  logic                bypass_flag;
  word_t               col_word;
  word_t               col_mixed;
  word_t               col_result;
  logic [NUM_COLS-1:0] col_we;

  // Handshake decode uses registered state only, so in_ready has no input-to-output path
  assign in_ready    = (state == IDLE);
  assign busy        = (state != IDLE);
  assign accept      = in_valid && in_ready;
  assign bypass_flag = in_bypass && BYPASS_EN;

  // The work register, not in_state, feeds the datapath so the source may change after accept
  assign col_word = get_col(work, cnt);

  mixCol32 u_mix (
    .word  (col_word),
    .mixed (col_mixed)
  );

  // A block captured with bypass never enters MIX; the mux keeps a bypassed column unmixed regardless
  assign col_result = bypass_q ? col_word : col_mixed;

  // One-hot write enable for the output column selected by the counter while mixing
  always_comb begin
    col_we = '0;
    if (state == MIX) begin
      col_we[cnt] = 1'b1;
    end
  end

  // Sequencer FSM: accept, walk four columns, hold the result until the consumer takes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      bypass_q  <= 1'b0;
      work      <= '0;
      out_state <= '0;
      out_valid <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_COLS; c++) begin
        if (col_we[c]) begin
          out_state[(NUM_COLS - 1 - c) * COL_W +: COL_W] <= col_result;
        end
      end

      case (state)
        IDLE: begin
          cnt       <= 2'd0;
          out_valid <= 1'b0;
          if (accept) begin
            work     <= in_state;
            bypass_q <= bypass_flag;
            if (bypass_flag) begin
              out_state <= in_state;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= MIX;
            end
          end
        end

        MIX: begin
          // Counter wraps 3 -> 0 on the same edge that leaves for DONE
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          cnt <= 2'd0;
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          cnt       <= 2'd0;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mix_col_sequencer.sv
// Self-checking bench for mix_col_sequencer against a GF(2^8) matrix-product reference.
// Latency: n/a.
// Backpressure: exercised through held-low out_ready windows.
module tb_mix_col_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_bypass = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_state = '0;

  logic         in_ready;
  logic         out_valid;
  logic         busy;
  logic [127:0] out_state;

  logic         nb_in_ready;
  logic         nb_out_valid;
  logic         nb_busy;
  logic [127:0] nb_out_state;

  int checks = 0;
  int failures = 0;

  localparam logic [127:0] VEC_A     = 128'hdb135345_f20a225c_01010101_2d26314c;
  localparam logic [127:0] VEC_A_MIX = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
  localparam logic [127:0] VEC_B     = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] VEC_C     = 128'hd4d4d4d5_c6c6c6c6_01010101_d4d4d4d5;
  localparam logic [127:0] VEC_C_MIX = 128'hd5d5d7d6_c6c6c6c6_01010101_d5d5d7d6;

  always #5 clk = ~clk;

  mix_col_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_bypass (in_bypass),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  mix_col_sequencer #(.BYPASS_EN(1'b0)) dut_nb (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (nb_in_ready),
    .in_state  (in_state),
    .in_bypass (in_bypass),
    .out_valid (nb_out_valid),
    .out_ready (out_ready),
    .out_state (nb_out_state),
    .busy      (nb_busy)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Generic shift-and-add GF(2^8) multiply
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? (8'({x, 1'b0}) ^ 8'h1b) : 8'({x, 1'b0});
      y = y >> 1;
    end
    return p;
  endfunction

  // Each column multiplied by the circulant matrix with first row {2,3,1,1}
  function automatic logic [127:0] mix_model(input logic [127:0] s);
    logic [7:0]   coef [4];
    logic [7:0]   a [4];
    logic [7:0]   b;
    logic [127:0] r;
    coef[0] = 8'd2; coef[1] = 8'd3; coef[2] = 8'd1; coef[3] = 8'd1;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[127 - 32*c - 8*k -: 8];
      for (int row = 0; row < 4; row++) begin
        b = 8'h00;
        for (int k = 0; k < 4; k++) b = b ^ gmul(coef[(k - row + 4) % 4], a[k]);
        r[127 - 32*c - 8*row -: 8] = b;
      end
    end
    return r;
  endfunction

  // Called at a negedge; returns at a negedge after the output handshake
  task automatic run_block(input logic [127:0] st, input logic byp, input int hold, input string tag);
    logic [127:0] exp;
    logic [127:0] held;
    int           lat;
    exp = byp ? st : mix_model(st);
    chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    in_valid  = 1'b1;
    in_state  = st;
    in_bypass = byp;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_bypass = 1'($urandom);
    in_state  = {$urandom, $urandom, $urandom, $urandom};
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      in_valid = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 128'(lat), byp ? 128'(0) : 128'(4));
    chk({tag, "_data"}, out_state, exp);
    chk({tag, "_busy"}, 128'(busy), 128'(1));
    held = out_state;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      @(negedge clk);
      chk({tag, "_hold_valid"}, 128'(out_valid), 128'(1));
      chk({tag, "_hold_data"}, out_state, held);
      chk({tag, "_hold_ready"}, 128'(in_ready), 128'(0));
      chk({tag, "_hold_busy"}, 128'(busy), 128'(1));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_post_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_post_ready"}, 128'(in_ready), 128'(1));
    chk({tag, "_post_busy"}, 128'(busy), 128'(0));
    chk({tag, "_post_data"}, out_state, held);
  endtask

  initial begin
    int           acc_cyc [$];
    logic [127:0] outs [$];
    int           first_out;
    int           lat;
    int           stray;
    logic         acc;

    // Reset state
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_state", out_state, 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_busy", 128'(busy), 128'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // First accept on the first edge after reset release, then the directed vectors
    run_block(VEC_A, 1'b0, 0, "mix");
    chk("mix_const", dut.out_state, VEC_A_MIX);
    run_block(VEC_B, 1'b1, 0, "bypass");
    chk("bypass_const", out_state, VEC_B);
    run_block(VEC_A, 1'b0, 10, "backpressure");

    // Back-to-back with in_valid held high throughout
    first_out = -1;
    in_valid  = 1'b1;
    in_state  = VEC_A;
    in_bypass = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && outs.size() < 2; i++) begin
      if (out_valid) begin
        outs.push_back(out_state);
        if (first_out < 0) first_out = i - 1;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        acc_cyc.push_back(i);
        if (acc_cyc.size() == 1) in_state = VEC_C;
        else in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_accepts", 128'(acc_cyc.size()), 128'(2));
    chk("b2b_outputs", 128'(outs.size()), 128'(2));
    if (acc_cyc.size() == 2) chk("b2b_gap", 128'(acc_cyc[1] - acc_cyc[0]), 128'(6));
    if (acc_cyc.size() >= 1) chk("b2b_first_latency", 128'(first_out - acc_cyc[0]), 128'(4));
    if (outs.size() == 2) begin
      chk("b2b_first_data", outs[0], VEC_A_MIX);
      chk("b2b_second_data", outs[1], VEC_C_MIX);
    end

    // Reset in the middle of MIX with cnt == 2
    in_valid  = 1'b1;
    in_state  = VEC_C;
    in_bypass = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy", 128'(busy), 128'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_out_state", out_state, 128'(0));
    chk("mid_rst_in_ready", 128'(in_ready), 128'(1));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    out_ready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (out_valid || nb_out_valid) stray++;
    end
    out_ready = 1'b0;
    chk("rst_no_stray", 128'(stray), 128'(0));

    // BYPASS_EN = 0 ignores in_bypass and still mixes
    in_valid  = 1'b1;
    in_bypass = 1'b1;
    in_state  = VEC_A;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_bypass = 1'b0;
    in_state  = '0;
    lat = 0;
    @(negedge clk);
    while (!nb_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("param_latency", 128'(lat), 128'(4));
    chk("param_data", nb_out_state, VEC_A_MIX);
    chk("param_bypass_dut", out_state, VEC_A);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("param_idle", 128'(nb_in_ready), 128'(1));

    // Randomized blocks against the reference model
    for (int n = 0; n < 30; n++) begin
      run_block({$urandom, $urandom, $urandom, $urandom}, 1'($urandom),
                int'($urandom_range(0, 3)), $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
